// File: rtl/tx_msg_sequencer.sv
// rtl/tx_msg_sequencer.sv - steps a fixed character message into a UART transmitter, periodically or on request
//
// Ports:
//   CLK          - rising-edge clock
//   RSTn         - asynchronous active-low reset
//   Mode         - 0 = send every PERIOD cycles, 1 = send once per Start_Sig
//   Start_Sig    - single-cycle send request (used only when Mode = 1)
//   TX_Done_Sig  - one-cycle pulse from the transmitter: current character sent
//   TX_En_Sig    - transmit request, high while a character is offered
//   TX_Data      - character being offered (always MSG character Byte_Idx)
//   Byte_Idx     - index of the current character
//   Busy         - high from message start through the DONE cycle
//   Msg_Done_Sig - one-cycle pulse in the DONE state
//   Overrun      - sticky: a trigger arrived while a message was in progress

module tx_msg_sequencer #(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          MSG_LEN = 4,
  parameter logic [16*DATA_W-1:0] MSG     = (16*DATA_W)'(32'h0A0D6948),
  parameter logic [31:0]          PERIOD  = 32'd50_000_000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Mode,
  input  logic              Start_Sig,
  input  logic              TX_Done_Sig,
  output logic              TX_En_Sig,
  output logic [DATA_W-1:0] TX_Data,
  output logic [3:0]        Byte_Idx,
  output logic              Busy,
  output logic              Msg_Done_Sig,
  output logic              Overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  function automatic logic [DATA_W-1:0] char_at(input logic [3:0] k);
    return MSG[int'(k)*DATA_W +: DATA_W];
  endfunction

  state_t              state_q;
  logic [31:0]         cnt_q;
  logic [31:0]         cnt_d;
  logic [3:0]          idx_q;
  logic [DATA_W-1:0]   data_q;
  logic                tx_en_q;
  logic                busy_q;
  logic                msg_done_q;
  logic                overrun_q;
  logic                tick;
  logic                trigger;

  // Free-running interval counter; it never pauses, so the tick grid is
  // fixed relative to reset regardless of message activity.
  assign tick    = (cnt_q == PERIOD - 32'd1);
  assign cnt_d   = tick ? 32'd0 : cnt_q + 32'd1;
  assign trigger = Mode ? Start_Sig : tick;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      idx_q      <= 4'd0;
      data_q     <= char_at(4'd0);
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      msg_done_q <= 1'b0;

      // Triggers are never queued: one that lands outside IDLE is lost.
      if (trigger && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= SEND;
            tx_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (TX_Done_Sig) begin
            tx_en_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q    <= DONE;
              msg_done_q <= 1'b1;
            end else begin
              // Advance the index now so the next character is already
              // settled on TX_Data during the one-cycle gap.
              state_q <= GAP;
              idx_q   <= idx_q + 4'd1;
              data_q  <= char_at(idx_q + 4'd1);
            end
          end
        end
        GAP: begin
          state_q <= SEND;
          tx_en_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= 4'd0;
          data_q  <= char_at(4'd0);
        end
        default: begin
          state_q <= IDLE;
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= 4'd0;
          data_q  <= char_at(4'd0);
        end
      endcase
    end
  end

  assign TX_En_Sig    = tx_en_q;
  assign TX_Data      = data_q;
  assign Byte_Idx     = idx_q;
  assign Busy         = busy_q;
  assign Msg_Done_Sig = msg_done_q;
  assign Overrun      = overrun_q;

endmodule
